// File: rtl/de10lite_io_pkg.sv
// Shared widths, reset values and debounce FSM state type for the DE10-Lite
// input conditioner.
package de10lite_io_pkg;

    localparam int unsigned KEY_W                   = 2;
    localparam int unsigned SW_W                    = 10;
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1000000;  // 20 ms at 50 MHz

    // Keys are active-low, so an idle key reads as 1.
    localparam logic [KEY_W-1:0] KEY_RESET = 2'b11;
    localparam logic [SW_W-1:0]  SW_RESET  = 10'b0;

    typedef enum logic {
        StStable   = 1'b0,
        StSettling = 1'b1
    } db_state_e;

endpackage

// File: rtl/debounce_bit.sv
// Single-bit synchroniser plus debouncer.
//   i_clk   : system clock, rising edge
//   i_rst_n : synchronous active-low reset
//   i_raw   : asynchronous input bit
//   o_level : debounced level (registered)
//   o_load  : high in the cycle before o_level takes a new value
//             (combinational strobe, used by the parent for edge pulses)
module debounce_bit
    import de10lite_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter logic        RESET_VAL       = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_load
);

    localparam int unsigned        CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_d;
    db_state_e              r_state;
    db_state_e              w_state_d;
    logic                   r_level;
    logic                   w_level_d;
    logic                   w_synced;
    logic                   w_differ;

    assign w_synced = r_sync[SYNC_STAGES-1];
    assign w_differ = (w_synced != r_level);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync  <= {SYNC_STAGES{RESET_VAL}};
            r_state <= StStable;
            r_cnt   <= '0;
            r_level <= RESET_VAL;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_raw};
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_level <= w_level_d;
        end
    end

    // Entering SETTLING counts the first differing edge as 1, so the counter
    // reaches CNT_LAST after DEBOUNCE_CYCLES-1 edges and the load lands on
    // the DEBOUNCE_CYCLES-th edge after the synchroniser output changed.
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_level_d = r_level;
        o_load    = 1'b0;
        unique case (r_state)
            StStable: begin
                if (w_differ) begin
                    w_state_d = StSettling;
                    w_cnt_d   = CNT_W'(1);
                end else begin
                    w_cnt_d = '0;
                end
            end
            StSettling: begin
                if (!w_differ) begin
                    // Glitch: drop the candidate level.
                    w_state_d = StStable;
                    w_cnt_d   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_d = StStable;
                    w_cnt_d   = '0;
                    w_level_d = w_synced;
                    o_load    = 1'b1;
                end else begin
                    w_cnt_d = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_d = StStable;
                w_cnt_d   = '0;
            end
        endcase
    end

    assign o_level = r_level;

endmodule

// File: rtl/de10lite_input_conditioner.sv
// Debounces the DE10-Lite pushbuttons and slide switches for the system PIOs
// and generates key-press and slider-change pulses.
//   clk_clk                            : system clock
//   reset_reset_n                      : synchronous active-low reset
//   key_raw[1:0]                       : raw pushbuttons, active-low
//   sw_raw[9:0]                        : raw slide switches, 1 = up
//   key_external_connection_export     : debounced keys, active-low
//   sliders_external_connection_export : debounced switches
//   key_press_pulse[1:0]               : one-cycle pulse per debounced press
//   sliders_change                     : one-cycle pulse on any switch update
module de10lite_input_conditioner
    import de10lite_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic [KEY_W-1:0] key_raw,
    input  logic [SW_W-1:0]  sw_raw,
    output logic [KEY_W-1:0] key_external_connection_export,
    output logic [SW_W-1:0]  sliders_external_connection_export,
    output logic [KEY_W-1:0] key_press_pulse,
    output logic             sliders_change
);

    logic [KEY_W-1:0] w_key_level;
    logic [KEY_W-1:0] w_key_load;
    logic [SW_W-1:0]  w_sw_level;
    logic [SW_W-1:0]  w_sw_load;
    logic [KEY_W-1:0] r_key_pulse;
    logic             r_sw_change;

    for (genvar g = 0; g < KEY_W; g++) begin : g_key
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .SYNC_STAGES     (SYNC_STAGES),
            .RESET_VAL       (KEY_RESET[g])
        ) u_db (
            .i_clk   (clk_clk),
            .i_rst_n (reset_reset_n),
            .i_raw   (key_raw[g]),
            .o_level (w_key_level[g]),
            .o_load  (w_key_load[g])
        );
    end

    for (genvar g = 0; g < SW_W; g++) begin : g_sw
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .SYNC_STAGES     (SYNC_STAGES),
            .RESET_VAL       (SW_RESET[g])
        ) u_db (
            .i_clk   (clk_clk),
            .i_rst_n (reset_reset_n),
            .i_raw   (sw_raw[g]),
            .o_level (w_sw_level[g]),
            .o_load  (w_sw_load[g])
        );
    end

    // Pulses are registered on the same edge as the level update, so they are
    // high for exactly the cycle that follows it. A load on a key whose level
    // is still 1 can only be a press (1->0); releases never pulse.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_key_pulse <= '0;
            r_sw_change <= 1'b0;
        end else begin
            r_key_pulse <= w_key_load & w_key_level;
            r_sw_change <= |w_sw_load;
        end
    end

    assign key_external_connection_export     = w_key_level;
    assign sliders_external_connection_export = w_sw_level;
    assign key_press_pulse                    = r_key_pulse;
    assign sliders_change                     = r_sw_change;

endmodule

// File: doc/de10lite_input_conditioner.md
DE10LITE_INPUT_CONDITIONER -- requirements
Module: de10lite_input_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000 (20 ms at 50 MHz), meaning the consecutive cycles a synchronised input must hold a new level before it is accepted; legal range 2..2^24.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, meaning the synchroniser flop depth per input; legal range 2..3.
REQ-003 Port clk_clk  in  1  single system clock; all state is updated on its rising edge.
REQ-004 Port reset_reset_n  in  1  synchronous, active-low reset.
REQ-005 Port key_raw  in  2  asynchronous DE10-Lite pushbuttons, active-low (0 = pressed).
REQ-006 Port sw_raw  in  10  asynchronous slide switches, 1 = up.
REQ-007 Port key_external_connection_export  out  2  debounced keys, active-low, driving the system key PIO.
REQ-008 Port sliders_external_connection_export  out  10  debounced switches, driving the system sliders PIO.
REQ-009 Port key_press_pulse  out  2  one-cycle pulse per key on each debounced press (1->0 transition).
REQ-010 Port sliders_change  out  1  one-cycle pulse when any debounced switch value changes.

Function
REQ-011 Each of the 12 input bits SHALL pass through its own SYNC_STAGES-deep flop chain before any other use.
REQ-012 Each bit SHALL implement a two-state FSM (STABLE, SETTLING) with its own counter of width clog2(DEBOUNCE_CYCLES).
REQ-013 STABLE: synced == debounced, counter = 0; on synced != debounced -> SETTLING, counter = 1.
REQ-014 SETTLING: while synced != debounced, increment counter; on the edge where the counter = DEBOUNCE_CYCLES-1 and synced still differs, load debounced <= synced, clear the counter, and go to STABLE.
REQ-015 SETTLING: if synced == debounced (glitch), clear the counter and return to STABLE with no output change.
REQ-016 Latency: a clean level change SHALL appear on the output at the (SYNC_STAGES+DEBOUNCE_CYCLES)-th rising edge, counting the first edge that samples the new raw level as 1.
REQ-017 key_press_pulse[i] SHALL be high for exactly the one cycle following the edge on which debounced key i goes 1->0.
REQ-018 A key release (0->1) SHALL NOT pulse.
REQ-019 Both keys pressing on the same edge SHALL pulse both bits in the same cycle.
REQ-020 sliders_change SHALL be high for one cycle after any edge on which one or more switch bits update; several bits updating on one edge SHALL give a single pulse.
REQ-021 A switch that reaches a new level while a previous sliders_change pulse is high SHALL produce its own pulse on the following cycle; no update SHALL be lost.
REQ-022 A held level SHALL never produce a counter overflow or wrap; the counter saturates structurally because REQ-014 clears it.
REQ-023 All outputs SHALL be registered; there SHALL be no combinational path from raw inputs to outputs.

Reset
REQ-024 While reset_reset_n = 0 at an edge: key sync flops and key_external_connection_export = 2'b11, switch sync flops and sliders_external_connection_export = 10'b0, all counters = 0, all FSMs = STABLE, key_press_pulse = 0, sliders_change = 0.
REQ-025 Asserting reset mid-SETTLING SHALL discard the pending change and emit no pulse.
REQ-026 After release, any switch already up SHALL be accepted through normal debounce timing and SHALL produce a sliders_change pulse.

Structure
REQ-027 Package de10lite_io_pkg SHALL hold KEY_W = 2, SW_W = 10, DEBOUNCE_CYCLES_DEFAULT, KEY_RESET = 2'b11, SW_RESET = 10'b0, and the debounce FSM state enum.
REQ-028 Sub-module debounce_bit (synchroniser, counter, FSM, reset-value parameter) SHALL be instantiated 12 times; edge and pulse logic SHALL live in the top level.

Verification (DEBOUNCE_CYCLES = 8, SYNC_STAGES = 2)
REQ-029 Reset: hold reset_reset_n = 0 for 3 cycles with key_raw = 2'b00 -> key export = 2'b11, sliders = 0, no pulses; after release key export reaches 2'b00 on edge 10 and key_press_pulse = 2'b11 for one cycle.
REQ-030 Clean press: key_raw[0] 1->0 sampled at edge 1 -> key export[0] = 0 at edge 10, key_press_pulse[0] high cycle 10 only; release -> no pulse.
REQ-031 Glitch: key_raw[1] low for 5 cycles then high -> no output change, no pulse, counter returns to 0.
REQ-032 Bounce: sw_raw[3] toggles every 3 cycles for 30 cycles then holds 1 -> a single update 10 edges after the final toggle, one sliders_change pulse.
REQ-033 Simultaneous: sw_raw = 10'h3FF on one edge -> all bits update on the same edge, exactly one sliders_change pulse.
REQ-034 Reset mid-settling: press key 0, assert reset at edge 6 -> export stays 2'b11, no pulse; debounce restarts from zero after release.
